pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register (EX/MEM, MEM/WB, ...) with valid/ready flow control,
//  2-entry skid buffer, flush-to-bubble and sticky halt. Sits between any two CPU pipeline

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_entry_reg.sv | 50 +++++
 rtl/pipe_stage_skid.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding, default widths
// and the control-bundle bit layout used by MEM/WB instances.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_LANES = 5;
  localparam int DEF_CTRL_W    = 8;
  localparam int DEF_CNT_W     = 16;

  // MEM/WB control layout: four flags followed by the 5-bit destination register.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_JAL      = 2;
  localparam int CTRL_LUI      = 3;
  localparam int CTRL_RW_LSB   = 4;
  localparam int CTRL_RW_W     = 5;
  localparam int CTRL_W_MEMWB  = CTRL_RW_LSB + CTRL_RW_W;

endpackage

// File: rtl/pipe_entry_reg.sv
// One held beat {valid, halt, ctrl, data}. Clear invalidates the entry and zeroes
// ctrl/halt but keeps data, so a squashed head still shows its last data lanes.
module pipe_entry_reg #(
  parameter int CTRL_W = 8,
  parameter int DBITS  = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              in_halt,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DBITS-1:0]  in_data,
  output logic              out_valid,
  output logic              out_halt,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DBITS-1:0]  out_data
);

  logic              r_valid;
  logic              r_halt;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DBITS-1:0]  r_data;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  // NOTE: the data field is reset too, because out_data must read 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
      r_ctrl  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_halt  <= in_halt;
      r_ctrl  <= in_ctrl;
      r_data  <= in_data;
    end
  end

  assign out_valid = r_valid;
  assign out_halt  = r_halt;
  assign out_ctrl  = r_ctrl;
  assign out_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready flow control, a head + skid entry pair,
// flush-to-bubble, sticky halt and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CTRL_W-1:0]             in_ctrl,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic                          in_halt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CTRL_W-1:0]             out_ctrl,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic                          out_halt,
  output logic [1:0]                    occupancy,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int DBITS = NUM_LANES * DATA_W;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_in_ready;
  logic              r_halt_seen;
  logic              r_out_halt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_accept;
  logic              w_pop;
  logic              w_halt_seen_nxt;
  logic              w_head_load;
  logic              w_head_clear;
  logic              w_head_from_skid;
  logic              w_skid_load;
  logic              w_skid_clear;

  logic              w_head_valid;
  logic              w_head_halt;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [DBITS-1:0]  w_head_data;
  logic              w_skid_valid;
  logic              w_skid_halt;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DBITS-1:0]  w_skid_data;

  logic              w_head_in_halt;
  logic [CTRL_W-1:0] w_head_in_ctrl;
  logic [DBITS-1:0]  w_head_in_data;

  assign w_accept        = in_valid & r_in_ready;
  assign w_pop           = w_head_valid & out_ready;
  assign w_halt_seen_nxt = r_halt_seen | (w_accept & in_halt);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_head_load      = 1'b0;
    w_head_clear     = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_head_clear = 1'b1;
      w_skid_clear = 1'b1;
      w_state_nxt  = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_head_load = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_accept && !w_pop) begin
            w_skid_load = 1'b1;
            w_state_nxt = TWO;
          end else if (w_accept && w_pop) begin
            w_head_load = 1'b1;
          end else if (w_pop) begin
            w_head_clear = 1'b1;
            w_state_nxt  = EMPTY;
          end
        end
        TWO: begin
          if (w_pop && w_skid_valid) begin
            w_head_load      = 1'b1;
            w_head_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
            w_state_nxt      = ONE;
          end
        end
        default: begin
          w_head_clear = 1'b1;
          w_skid_clear = 1'b1;
          w_state_nxt  = EMPTY;
        end
      endcase
    end
  end

  assign w_head_in_halt = w_head_from_skid ? w_skid_halt : in_halt;
  assign w_head_in_ctrl = w_head_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_head_in_data = w_head_from_skid ? w_skid_data : in_data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DBITS(DBITS)) u_head (
    .clk      (clk),
    .rst      (rst),
    .load     (w_head_load),
    .clear    (w_head_clear),
    .in_halt  (w_head_in_halt),
    .in_ctrl  (w_head_in_ctrl),
    .in_data  (w_head_in_data),
    .out_valid(w_head_valid),
    .out_halt (w_head_halt),
    .out_ctrl (w_head_ctrl),
    .out_data (w_head_data)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DBITS(DBITS)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (w_skid_load),
    .clear    (w_skid_clear),
    .in_halt  (in_halt),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(w_skid_valid),
    .out_halt (w_skid_halt),
    .out_ctrl (w_skid_ctrl),
    .out_data (w_skid_data)
  );

  // in_ready is a flop that comes out of reset already set: the stage is empty and unhalted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_halt_seen <= 1'b0;
      r_out_halt  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != TWO) && !w_halt_seen_nxt;
      r_halt_seen <= w_halt_seen_nxt;
      r_out_halt  <= r_out_halt | (w_head_valid & w_head_halt);
      if (w_head_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_head_valid;
  assign out_ctrl  = w_head_ctrl;
  assign out_data  = w_head_data;
  assign out_halt  = r_out_halt | (w_head_valid & w_head_halt);
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios with literal expectations plus a randomized
// run, all cross-checked every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int NL = 5;
  localparam int CW = 8;
  localparam int KW = 4;
  localparam int DB = DW * NL;
  localparam int STALL_MAX = (1 << KW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DB-1:0] in_data = '0;
  logic          in_halt = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DB-1:0] out_data;
  logic          out_halt;
  logic [1:0]    occupancy;
  logic [KW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .NUM_LANES(NL), .CTRL_W(CW), .CNT_W(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .in_halt  (in_halt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .out_halt (out_halt),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two beats plus sticky flags and a counter.
  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DB-1:0] data;
    logic          halt;
  } beat_t;

  beat_t         m_q[$];
  bit            m_halt_seen = 1'b0;
  bit            m_out_halt = 1'b0;
  bit            m_ready = 1'b1;
  bit            m_init = 1'b0;
  bit            m_acc;
  bit            m_pop;
  int            m_stall = 0;
  logic [DB-1:0] m_out_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_halt_seen = 1'b0;
      m_out_halt  = 1'b0;
      m_stall     = 0;
      m_out_data  = '0;
    end else begin
      m_acc = in_valid && m_ready;
      m_pop = (m_q.size() > 0) && out_ready;
      if ((m_q.size() > 0) && !out_ready && (m_stall < STALL_MAX)) m_stall++;
      if (m_acc && in_halt) m_halt_seen = 1'b1;
      if (flush) begin
        m_q.delete();
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_acc) m_q.push_back('{in_ctrl, in_data, in_halt});
      end
    end
    if (m_q.size() > 0) begin
      m_out_data = m_q[0].data;
      if (m_q[0].halt) m_out_halt = 1'b1;
    end
    m_ready = (m_q.size() < 2) && !m_halt_seen;
    m_init  = 1'b1;
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic [CW-1:0] exp_ctrl;
      exp_ctrl = '0;
      if (m_q.size() > 0) exp_ctrl = m_q[0].ctrl;
      check("m_out_valid", out_valid, m_q.size() > 0);
      check("m_out_ctrl", out_ctrl, exp_ctrl);
      check("m_out_data", out_data, m_out_data);
      check("m_out_halt", out_halt, m_out_halt);
      check("m_occupancy", occupancy, m_q.size());
      check("m_stall_cnt", stall_cnt, m_stall);
      check("m_in_ready", in_ready, m_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] lane0, input bit h,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = {lane0 + 32'd4, lane0 + 32'd3, lane0 + 32'd2, lane0 + 32'd1, lane0};
    in_ctrl   = lane0[CW-1:0];
    in_halt   = h;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 32'd0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held two cycles while a beat is offered.
    rst = 1'b1;
    drive(1, 32'h55, 0, 1, 0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl", out_ctrl, '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_halt", out_halt, 1'b0);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_stall_cnt", stall_cnt, '0);
    rst = 1'b0;
    drive(0, 32'd0, 0, 1, 0);
    check("rst_in_ready", in_ready, 1'b1);

    // Streaming: each beat shows on the output one cycle after acceptance.
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, 0, 1, 0);
      tick();
      check("stream_lane0", out_data[DW-1:0], i);
      check("stream_lane4", out_data[DB-1 -: DW], i + 4);
      check("stream_occ_le1", occupancy <= 2'd1, 1'b1);
    end
    drive(0, 32'd0, 0, 1, 0);
    tick();
    check("stream_drained", out_valid, 1'b0);
    check("stream_stall", stall_cnt, '0);

    // Backpressure: A and B fill the stage, C waits, then all three drain in order.
    drive(1, 32'hA, 0, 0, 0);
    tick();
    drive(1, 32'hB, 0, 0, 0);
    tick();
    drive(1, 32'hC, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_occ_full", occupancy, 2'd2);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_head_A", out_data[DW-1:0], 32'hA);
    end
    check("bp_stall", stall_cnt, 4'd4);
    out_ready = 1'b1;
    tick();
    check("bp_head_B", out_data[DW-1:0], 32'hB);
    tick();
    check("bp_head_C", out_data[DW-1:0], 32'hC);
    drive(0, 32'd0, 0, 1, 0);
    tick();
    check("bp_drained", out_valid, 1'b0);
    check("bp_stall_final", stall_cnt, 4'd4);

    // Flush with a full stage while D is offered.
    do_reset();
    drive(1, 32'h21, 0, 0, 0);
    tick();
    drive(1, 32'h22, 0, 0, 0);
    tick();
    check("fl_occ_full", occupancy, 2'd2);
    drive(1, 32'hD0, 0, 0, 1);
    tick();
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_out_ctrl", out_ctrl, '0);
    check("fl_occ", occupancy, 2'd0);
    check("fl_data_hold", out_data[DW-1:0], 32'h21);
    // A beat accepted in the flush cycle is dropped.
    drive(1, 32'h31, 0, 0, 0);
    tick();
    drive(1, 32'hD1, 0, 0, 1);
    tick();
    check("fl_drop_occ", occupancy, 2'd0);
    drive(0, 32'd0, 0, 1, 0);
    tick();
    tick();
    check("fl_no_D", out_valid, 1'b0);

    // Halt: H blocks further input, out_halt is sticky until reset.
    do_reset();
    drive(1, 32'h4A, 1, 0, 0);
    tick();
    check("halt_at_head", out_halt, 1'b1);
    check("halt_in_ready", in_ready, 1'b0);
    drive(1, 32'hE, 0, 0, 0);
    tick();
    tick();
    check("halt_E_blocked", occupancy, 2'd1);
    check("halt_head_H", out_data[DW-1:0], 32'h4A);
    drive(1, 32'hE, 0, 1, 0);
    tick();
    check("halt_popped", out_valid, 1'b0);
    check("halt_after_pop", out_halt, 1'b1);
    drive(1, 32'hE, 0, 1, 1);
    tick();
    check("halt_after_flush", out_halt, 1'b1);
    drive(1, 32'hE, 0, 1, 0);
    repeat (20) tick();
    check("halt_20_cycles", out_halt, 1'b1);
    check("halt_no_E", out_valid, 1'b0);
    do_reset();
    check("halt_cleared", out_halt, 1'b0);

    // Stall counter saturation.
    drive(1, 32'h77, 0, 0, 0);
    tick();
    drive(0, 32'd0, 0, 0, 0);
    repeat (20) tick();
    check("sat_stall", stall_cnt, 4'd15);

    // Randomized traffic in phases of differing downstream readiness.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      int rdy_pct;
      rdy_pct = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 20 : 70;
      for (int c = 0; c < 1000; c++) begin
        rst = ($urandom_range(0, 299) == 0);
        drive($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 399) == 0,
              $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 29) == 0);
        tick();
      end
    end
    rst = 1'b0;
    drive(0, 32'd0, 0, 1, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
